fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_perf_cnt.sv | 35 +++
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : fetch_pkg                                          |
// | Description : Shared types and constants for the fetch unit:     |
// |               FSM state enum, NOP encoding, default reset PC.    |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package fetch_pkg;

  // Fetch FSM states, explicitly encoded
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    KILL = 3'd4
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] C_NOP              = 32'h0000_0013;
  localparam logic [31:0] C_DEFAULT_RESET_PC = 32'h0000_0000;

  // Redirect targets are word aligned; the low two bits are dropped
  function automatic logic [31:0] align_target(input logic [31:0] target);
    return target & ~32'h0000_0003;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_perf_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : fetch_perf_cnt                                     |
// | Description : Free-running 32-bit event counters for presented   |
// |               fetches and HOLD (stall) cycles. Wrap at 2^32.     |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_evt,
  input  logic        stall_evt,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  // Count one per event pulse; natural 32-bit wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (fetch_evt) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (stall_evt) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : fetch_unit                                         |
// | Description : Single-outstanding instruction fetch FSM with      |
// |               redirect, downstream stall and response discard.   |
// |               Define FETCH_PERF_EN to add perf_fetch_cnt and     |
// |               perf_stall_cnt outputs.                            |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = C_DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        next_select,
  input  logic        branch_result,
  input  logic        jalr,
  input  logic [31:0] redirect_target,
  input  logic        load,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pre_address_pc,
  output logic [31:0] instruction_fetch,
  output logic        fetch_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_pre_pc;
  logic [31:0]  r_instr;
  logic         r_valid;

  logic         w_redirect;
  logic [31:0]  w_target;
  logic         w_accept;

  assign w_redirect = next_select | branch_result | jalr;
  assign w_target   = align_target(redirect_target);
  // A response in WAIT is kept only if no redirect lands in the same cycle
  assign w_accept   = (r_state == WAIT) && imem_rvalid && !w_redirect;

  // A redirect in REQ suppresses the strobe so the stale-PC request never
  // leaves; this keeps exactly one request in flight when we re-enter REQ.
  assign imem_req  = (r_state == REQ) && !w_redirect;
  assign imem_addr = r_pc;

  assign pre_address_pc    = r_pre_pc;
  assign instruction_fetch = r_instr;
  assign fetch_valid       = r_valid;

  // Fetch FSM, PC and registered presentation outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC;
      r_pre_pc <= '0;
      r_instr  <= C_NOP;
      r_valid  <= 1'b0;
    end else begin
      // Presentation lasts one cycle unless HOLD keeps it
      r_valid  <= 1'b0;
      r_instr  <= C_NOP;
      r_pre_pc <= '0;
      if (w_redirect) begin
        r_pc <= w_target;
        // An unanswered request must have its response swallowed in KILL
        if ((r_state == WAIT || r_state == KILL) && !imem_rvalid) begin
          r_state <= KILL;
        end else begin
          r_state <= REQ;
        end
      end else begin
        case (r_state)
          IDLE: r_state <= REQ;
          REQ:  r_state <= WAIT;
          WAIT: begin
            if (w_accept) begin
              r_valid  <= 1'b1;
              r_instr  <= imem_rdata;
              r_pre_pc <= r_pc;
              r_pc     <= r_pc + 32'd4;
              r_state  <= load ? HOLD : REQ;
            end
          end
          HOLD: begin
            if (load) begin
              r_valid  <= r_valid;
              r_instr  <= r_instr;
              r_pre_pc <= r_pre_pc;
            end else begin
              r_state <= REQ;
            end
          end
          KILL: begin
            if (imem_rvalid) r_state <= REQ;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef FETCH_PERF_EN
  fetch_perf_cnt u_perf_cnt (
    .clk       (clk),
    .rst       (rst),
    .fetch_evt (w_accept),
    .stall_evt (r_state == HOLD),
    .fetch_cnt (perf_fetch_cnt),
    .stall_cnt (perf_stall_cnt)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_fetch_unit                                      |
// | Description : Self-checking bench for fetch_unit: directed       |
// |               vector table, reset-in-flight sequence and a       |
// |               randomized run against a transaction-level model.  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        next_select, branch_result, jalr;
  logic [31:0] redirect_target;
  logic        load;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pre_address_pc;
  logic [31:0] instruction_fetch;
  logic        fetch_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  fetch_unit dut (
    .clk               (clk),
    .rst               (rst),
    .next_select       (next_select),
    .branch_result     (branch_result),
    .jalr              (jalr),
    .redirect_target   (redirect_target),
    .load              (load),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_rvalid       (imem_rvalid),
    .imem_rdata        (imem_rdata),
    .pre_address_pc    (pre_address_pc),
    .instruction_fetch (instruction_fetch),
    .fetch_valid       (fetch_valid)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_stall_cnt    (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory contents: arbitrary but address-dependent
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  // kind: 0 none, 1 next_select, 2 branch_result, 3 jalr
  typedef struct {
    logic [1:0]  kind;
    logic [31:0] tgt;
    logic        ld;
    logic        rv;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pre;
  } vec_t;

  vec_t tbl[28];

  task automatic drive_redirect(input logic [1:0] kind, input logic [31:0] tgt);
    next_select     = (kind == 2'd1);
    branch_result   = (kind == 2'd2);
    jalr            = (kind == 2'd3);
    redirect_target = tgt;
  endtask

  task automatic idle_inputs();
    drive_redirect(2'd0, 32'h0);
    load        = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
  endtask

  // Model state for the random phase
  logic [31:0] m_pc, e_instr, e_pre, mem_addr;
  logic        m_inflight, m_ok, m_hold, e_valid, mem_pend;
  logic        rv, redir, acc, keep;
  int          mem_cnt, idle, m_acc, m_stall;

  initial begin
    // ---------------- directed table ----------------
    //        kind  tgt            ld   rv   rd              req  addr           v    instr          pre
    tbl[0]  = '{2'd0, 32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,NOP,          32'h0};
    tbl[1]  = '{2'd0, 32'h0,        1'b0,1'b0,32'h0,        1'b1,32'h0,        1'b0,NOP,          32'h0};
    tbl[2]  = '{2'd0, 32'h0,        1'b0,1'b1,32'h0000_0093,1'b0,32'h0,        1'b0,NOP,          32'h0};
    tbl[3]  = '{2'd0, 32'h0,        1'b0,1'b0,32'h0,        1'b1,32'h4,        1'b1,32'h0000_0093,32'h0};
    tbl[4]  = '{2'd0, 32'h0,        1'b0,1'b1,32'hA1A1_0001,1'b0,32'h4,        1'b0,NOP,          32'h0};
    tbl[5]  = '{2'd0, 32'h0,        1'b0,1'b0,32'h0,        1'b1,32'h8,        1'b1,32'hA1A1_0001,32'h4};
    tbl[6]  = '{2'd0, 32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h8,        1'b0,NOP,          32'h0};
    tbl[7]  = '{2'd0, 32'h0,        1'b1,1'b1,32'hA2A2_0002,1'b0,32'h8,        1'b0,NOP,          32'h0};
    tbl[8]  = '{2'd0, 32'h0,        1'b1,1'b0,32'h0,        1'b0,32'hC,        1'b1,32'hA2A2_0002,32'h8};
    tbl[9]  = '{2'd0, 32'h0,        1'b1,1'b0,32'h0,        1'b0,32'hC,        1'b1,32'hA2A2_0002,32'h8};
    tbl[10] = '{2'd0, 32'h0,        1'b0,1'b0,32'h0,        1'b0,32'hC,        1'b1,32'hA2A2_0002,32'h8};
    tbl[11] = '{2'd0, 32'h0,        1'b0,1'b0,32'h0,        1'b1,32'hC,        1'b0,NOP,          32'h0};
    tbl[12] = '{2'd2, 32'h100,      1'b0,1'b0,32'h0,        1'b0,32'hC,        1'b0,NOP,          32'h0};
    tbl[13] = '{2'd0, 32'h0,        1'b0,1'b1,32'hDEAD_BEEF,1'b0,32'h100,      1'b0,NOP,          32'h0};
    tbl[14] = '{2'd0, 32'h0,        1'b0,1'b0,32'h0,        1'b1,32'h100,      1'b0,NOP,          32'h0};
    tbl[15] = '{2'd3, 32'h203,      1'b0,1'b1,32'hBAD0_0001,1'b0,32'h100,      1'b0,NOP,          32'h0};
    tbl[16] = '{2'd0, 32'h0,        1'b0,1'b0,32'h0,        1'b1,32'h200,      1'b0,NOP,          32'h0};
    tbl[17] = '{2'd0, 32'h0,        1'b0,1'b1,32'hA3A3_0003,1'b0,32'h200,      1'b0,NOP,          32'h0};
    tbl[18] = '{2'd0, 32'h0,        1'b0,1'b0,32'h0,        1'b1,32'h204,      1'b1,32'hA3A3_0003,32'h200};
    tbl[19] = '{2'd1, 32'hFFFF_FFFC,1'b0,1'b0,32'h0,        1'b0,32'h204,      1'b0,NOP,          32'h0};
    tbl[20] = '{2'd0, 32'h0,        1'b0,1'b1,32'hBAD0_0002,1'b0,32'hFFFF_FFFC,1'b0,NOP,          32'h0};
    tbl[21] = '{2'd0, 32'h0,        1'b0,1'b0,32'h0,        1'b1,32'hFFFF_FFFC,1'b0,NOP,          32'h0};
    tbl[22] = '{2'd0, 32'h0,        1'b0,1'b1,32'hA4A4_0004,1'b0,32'hFFFF_FFFC,1'b0,NOP,          32'h0};
    tbl[23] = '{2'd0, 32'h0,        1'b0,1'b0,32'h0,        1'b1,32'h0,        1'b1,32'hA4A4_0004,32'hFFFF_FFFC};
    tbl[24] = '{2'd1, 32'h80,       1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,NOP,          32'h0};
    tbl[25] = '{2'd0, 32'h0,        1'b0,1'b1,32'hBAD0_0003,1'b0,32'h80,       1'b0,NOP,          32'h0};
    tbl[26] = '{2'd0, 32'h0,        1'b0,1'b0,32'h0,        1'b1,32'h80,       1'b0,NOP,          32'h0};
    tbl[27] = '{2'd0, 32'h0,        1'b0,1'b0,32'h0,        1'b0,32'h80,       1'b0,NOP,          32'h0};

    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   {31'b0, imem_req}, 32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", {31'b0, fetch_valid}, 32'h0);
    chk("rst_instr", instruction_fetch, NOP);
    chk("rst_pre",   pre_address_pc, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 28; i++) begin
      drive_redirect(tbl[i].kind, tbl[i].tgt);
      load        = tbl[i].ld;
      imem_rvalid = tbl[i].rv;
      imem_rdata  = tbl[i].rd;
      #1;
      chk($sformatf("tbl%0d_req", i),   {31'b0, imem_req}, {31'b0, tbl[i].e_req});
      chk($sformatf("tbl%0d_addr", i),  imem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), {31'b0, fetch_valid}, {31'b0, tbl[i].e_valid});
      chk($sformatf("tbl%0d_instr", i), instruction_fetch, tbl[i].e_instr);
      if (tbl[i].e_valid) chk($sformatf("tbl%0d_pre", i), pre_address_pc, tbl[i].e_pre);
      @(posedge clk);
      #1;
    end

    // ---------------- reset while in WAIT ----------------
    idle_inputs();
    rst = 1'b0;
    #1;
    chk("midrst_req",   {31'b0, imem_req}, 32'h0);
    chk("midrst_addr",  imem_addr, 32'h0);
    chk("midrst_valid", {31'b0, fetch_valid}, 32'h0);
    chk("midrst_instr", instruction_fetch, NOP);
    chk("midrst_pre",   pre_address_pc, 32'h0);
    @(negedge clk);
    rst         = 1'b1;
    imem_rvalid = 1'b1;           // stale response arriving in IDLE
    imem_rdata  = 32'hBAD0_00FF;
    #1;
    chk("stale_idle_req", {31'b0, imem_req}, 32'h0);
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    #1;
    chk("postrst_req",   {31'b0, imem_req}, 32'h1);
    chk("postrst_addr",  imem_addr, 32'h0);
    chk("postrst_valid", {31'b0, fetch_valid}, 32'h0);
    @(posedge clk);
    #1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hA5A5_0005;
    #1;
    chk("postrst_wait_req", {31'b0, imem_req}, 32'h0);
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    #1;
    chk("postrst_fetch_valid", {31'b0, fetch_valid}, 32'h1);
    chk("postrst_fetch_instr", instruction_fetch, 32'hA5A5_0005);
    chk("postrst_fetch_pre",   pre_address_pc, 32'h0);
    chk("postrst_next_addr",   imem_addr, 32'h4);

    // ---------------- randomized run vs model ----------------
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    m_pc = 32'h0; m_inflight = 1'b0; m_ok = 1'b0; m_hold = 1'b0;
    e_valid = 1'b0; e_instr = NOP; e_pre = 32'h0;
    mem_pend = 1'b0; mem_cnt = 0; mem_addr = 32'h0;
    idle = 0; m_acc = 0; m_stall = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_valid", {31'b0, fetch_valid}, {31'b0, e_valid});
      chk("rnd_instr", instruction_fetch, e_valid ? e_instr : NOP);
      if (e_valid) chk("rnd_pre", pre_address_pc, e_pre);
      if (e_valid && m_hold) m_stall++;

      rv          = mem_pend && (mem_cnt == 0);
      imem_rvalid = rv;
      imem_rdata  = rv ? mem_f(mem_addr) : $urandom();
      case ($urandom_range(0, 15))
        0:       drive_redirect(2'd1, $urandom());
        1:       drive_redirect(2'd2, $urandom());
        2:       drive_redirect(2'd3, $urandom());
        default: drive_redirect(2'd0, $urandom());
      endcase
      load = ($urandom_range(0, 2) == 0);
      #1;
      redir = next_select | branch_result | jalr;

      if (imem_req) begin
        chk("rnd_one_outstanding", {31'b0, m_inflight}, 32'h0);
        chk("rnd_req_addr", imem_addr, m_pc);
      end

      // Fetch stream: a response counts only if its request postdates the
      // last redirect and no redirect arrives with it.
      acc  = rv && m_ok && !redir;
      if (rv) m_inflight = 1'b0;
      keep = e_valid && m_hold && load && !redir;
      if (acc) begin
        e_valid = 1'b1;
        e_instr = mem_f(mem_addr);
        e_pre   = m_pc;
        m_pc    = m_pc + 32'd4;
        m_hold  = load;
        m_acc++;
      end else if (!keep) begin
        e_valid = 1'b0;
        m_hold  = 1'b0;
      end
      if (imem_req) begin
        m_inflight = 1'b1;
        m_ok       = 1'b1;
      end
      if (redir) begin
        m_pc = {redirect_target[31:2], 2'b00};
        m_ok = 1'b0;
      end

      // Memory: one response 1..3 cycles after each request
      if (rv) mem_pend = 1'b0;
      else if (mem_pend) mem_cnt--;
      if (imem_req) begin
        mem_pend = 1'b1;
        mem_addr = imem_addr;
        mem_cnt  = $urandom_range(0, 2);
      end

      if (imem_req || redir || m_inflight || e_valid) idle = 0;
      else idle++;
      chk("rnd_progress", {31'b0, (idle > 4)}, 32'h0);
      if (idle > 4) idle = 0;

      @(posedge clk);
      #1;
    end

`ifdef FETCH_PERF_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, m_acc);
    chk("perf_stall_cnt", perf_stall_cnt, m_stall);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
